// File: rtl/fpa_fp16_to_int.sv
// rtl/fpa_fp16_to_int.sv - fp16 (FPSUM encoding) to saturating int16 converter
//
// Purpose:
//   Converts one 16-bit float (sign, 5-bit exponent with bias 15, 10-bit
//   fraction with hidden 1) into a two's-complement int16. The magnitude
//   is aligned by a bit-serial shifter, one position per clock.
//   Out-of-range values saturate (ovf). Nonzero values below 1 truncate
//   to 0 (unf).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   fp_in      [15] sign, [14:10] exponent, [9:0] fraction
//   in_valid   fp_in is valid
//   in_ready   converter idle and able to accept an operand
//   int_out    registered two's-complement result
//   out_valid  int_out / ovf / unf are valid
//   out_ready  consumer takes the result
//   ovf        result saturated (value outside int16 range)
//   unf        nonzero input truncated to 0 (magnitude below 1)

module fpa_fp16_to_int (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fp_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] int_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_mag;
  logic [3:0]  r_cnt;
  logic        r_left;
  logic        r_sign;
  logic [15:0] r_int_out;
  logic        r_out_valid;
  logic        r_ovf;
  logic        r_unf;

  // Operand decode
  logic        w_sign;
  logic [4:0]  w_exp;
  logic [9:0]  w_frac;
  logic [15:0] w_sat;
  logic [3:0]  w_cnt;
  logic        w_left;

  assign w_sign = fp_in[15];
  assign w_exp  = fp_in[14:10];
  assign w_frac = fp_in[9:0];

  // Saturation value follows the sign of the operand.
  assign w_sat  = w_sign ? 16'h8000 : 16'h7FFF;

  // Mantissa {1,M} has its binary point 10 bits up, so an exponent of 25
  // (unbiased 10) leaves it already aligned as an integer. Only used for
  // exponents 15..29, where the distance fits in 4 bits (max 10).
  assign w_left = (w_exp > 5'd25);
  assign w_cnt  = w_left ? 4'(w_exp - 5'd25) : 4'(5'd25 - w_exp);

  assign in_ready  = (r_state == S_IDLE);
  assign int_out   = r_int_out;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mag       <= 16'h0000;
      r_cnt       <= 4'd0;
      r_left      <= 1'b0;
      r_sign      <= 1'b0;
      r_int_out   <= 16'h0000;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            // Flags are rewritten on every classification so nothing
            // leaks from the previous result.
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            if (w_exp == 5'd0) begin
              // Zero encoding: fraction ignored.
              r_int_out <= 16'h0000;
              r_state   <= S_DONE;
            end else if (w_exp == 5'd31) begin
              r_int_out <= w_sat;
              r_ovf     <= 1'b1;
              r_state   <= S_DONE;
            end else if (w_exp == 5'd30) begin
              // 2^15 magnitude: only -32768 exactly is representable.
              if (w_sign && (w_frac == 10'd0)) begin
                r_int_out <= 16'h8000;
              end else begin
                r_int_out <= w_sat;
                r_ovf     <= 1'b1;
              end
              r_state <= S_DONE;
            end else if (w_exp < 5'd15) begin
              // Magnitude below 1 truncates to zero.
              r_int_out <= 16'h0000;
              r_unf     <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_mag   <= {5'b00000, 1'b1, w_frac};
              r_cnt   <= w_cnt;
              r_left  <= w_left;
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_FIN;
          end else begin
            // Zero-filling shift; right shifts drop bits, i.e. truncate
            // toward zero on the magnitude.
            r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_FIN: begin
          // Aligned magnitude is at most 0x7FF0, so negation cannot wrap.
          r_int_out   <= r_sign ? (~r_mag + 16'd1) : r_mag;
          r_ovf       <= 1'b0;
          r_unf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          // Results classified directly from IDLE raise out_valid one edge
          // after entering DONE; results from FIN arrive already valid.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpa_fp16_to_int.sv
// tb/tb_fpa_fp16_to_int.sv - self-checking bench for fpa_fp16_to_int

module tb_fpa_fp16_to_int;

  logic        clk;
  logic        rst_n;
  logic [15:0] fp_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] int_out;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        unf;

  int n_err;
  int n_chk;

  fpa_fp16_to_int dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fp_in     (fp_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .int_out   (int_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: real value of the float truncated toward zero, then range
  // checked against int16.
  function automatic void model(input logic [15:0] fp, output logic [15:0] r,
                                output logic o, output logic u, output int lat);
    int     e;
    int     m;
    longint v;
    longint sv;
    e = int'(fp[14:10]);
    m = int'(fp[9:0]);
    o = 1'b0;
    u = 1'b0;
    lat = 1;
    if (e >= 15 && e <= 29) lat = ((e > 25) ? (e - 25) : (25 - e)) + 2;
    if (e == 0) begin
      r = 16'h0000;
    end else if (e == 31) begin
      r = fp[15] ? 16'h8000 : 16'h7FFF;
      o = 1'b1;
    end else begin
      if (e >= 25) v = longint'(1024 + m) <<< (e - 25);
      else         v = longint'(1024 + m) >>> (25 - e);
      sv = fp[15] ? -v : v;
      if (sv > 32767 || sv < -32768) begin
        r = fp[15] ? 16'h8000 : 16'h7FFF;
        o = 1'b1;
      end else if (v == 0) begin
        r = 16'h0000;
        u = 1'b1;
      end else begin
        r = 16'(sv);
      end
    end
  endfunction

  // Compare process
  logic [15:0] m_int;
  logic        m_ovf;
  logic        m_unf;
  int          m_lat;
  bit          armed;
  int          edge_cnt;
  int          last_lat;
  bit          prev_ov;
  bit          prev_or;

  initial begin
    armed = 0; prev_ov = 0; prev_or = 0; last_lat = -1; edge_cnt = 0;
    m_int = 16'h0; m_ovf = 0; m_unf = 0; m_lat = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      armed   = 0;
      prev_ov = 0;
      prev_or = 0;
    end else begin
      if (prev_ov && prev_or) begin
        chk(!out_valid, "consume_out_valid", 32'(out_valid), 32'd0);
        chk(in_ready, "consume_in_ready", 32'(in_ready), 32'd1);
      end
      if (armed) begin
        edge_cnt++;
        if (out_valid) begin
          chk(edge_cnt == m_lat, "latency", 32'(edge_cnt), 32'(m_lat));
          last_lat = edge_cnt;
          armed = 0;
        end else if (edge_cnt > 40) begin
          chk(1'b0, "latency_timeout", 32'(edge_cnt), 32'(m_lat));
          armed = 0;
        end
      end
      if (out_valid) begin
        chk(int_out == m_int, "int_out", 32'(int_out), 32'(m_int));
        chk(ovf == m_ovf, "ovf", 32'(ovf), 32'(m_ovf));
        chk(unf == m_unf, "unf", 32'(unf), 32'(m_unf));
        chk(!in_ready, "busy_in_ready", 32'(in_ready), 32'd0);
      end
      if (in_valid && in_ready) begin
        model(fp_in, m_int, m_ovf, m_unf, m_lat);
        armed    = 1;
        edge_cnt = -1;
      end
      prev_ov = out_valid;
      prev_or = out_ready;
    end
  end

  logic [15:0] cap_int;
  logic        cap_ovf;
  logic        cap_unf;

  // Offer fp, wait for the result, hold it for `hold` cycles while a
  // distracting operand is presented, then consume it.
  task automatic conv(input logic [15:0] fp, input int hold);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #2; guard++;
    end
    chk(in_ready, "accept_timeout", 32'(in_ready), 32'd1);
    fp_in     = fp;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    fp_in    = 16'($urandom);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #2; guard++;
    end
    chk(out_valid, "result_timeout", 32'(out_valid), 32'd1);
    cap_int = int_out;
    cap_ovf = ovf;
    cap_unf = unf;
    for (int h = 0; h < hold; h++) begin
      fp_in    = ~fp;
      in_valid = 1'b1;
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  task automatic directed(input logic [15:0] fp, input logic [15:0] e_int,
                          input logic e_ovf, input logic e_unf, input int e_lat, input int hold);
    logic [15:0] r;
    logic        o;
    logic        u;
    int          l;
    model(fp, r, o, u, l);
    chk(r == e_int && o == e_ovf && u == e_unf && l == e_lat, "model_pin",
        {r, 7'd0, o, u, 7'(l)}, {e_int, 7'd0, e_ovf, e_unf, 7'(e_lat)});
    conv(fp, hold);
    chk(cap_int == e_int, "lit_int_out", 32'(cap_int), 32'(e_int));
    chk(cap_ovf == e_ovf, "lit_ovf", 32'(cap_ovf), 32'(e_ovf));
    chk(cap_unf == e_unf, "lit_unf", 32'(cap_unf), 32'(e_unf));
    chk(last_lat == e_lat, "lit_latency", 32'(last_lat), 32'(e_lat));
  endtask

  initial begin
    logic [4:0] e;
    n_err = 0;
    n_chk = 0;
    rst_n     = 1'b0;
    fp_in     = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk(int_out == 16'h0 && !out_valid && !ovf && !unf, "reset_outputs",
        {int_out, 13'd0, out_valid, ovf, unf}, 32'd0);
    chk(in_ready, "reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #2;

    directed(16'h3C00, 16'h0001, 1'b0, 1'b0, 12, 0);
    directed(16'hC900, 16'hFFF6, 1'b0, 1'b0, 9, 0);
    directed(16'h77FF, 16'h7FF0, 1'b0, 1'b0, 6, 0);
    directed(16'h7BFF, 16'h7FFF, 1'b1, 1'b0, 1, 0);
    directed(16'hFC00, 16'h8000, 1'b1, 1'b0, 1, 0);
    directed(16'hF800, 16'h8000, 1'b0, 1'b0, 1, 0);
    directed(16'h3800, 16'h0000, 1'b0, 1'b1, 1, 0);
    directed(16'h0000, 16'h0000, 1'b0, 1'b0, 1, 0);
    directed(16'h03FF, 16'h0000, 1'b0, 1'b0, 1, 0);
    directed(16'h6400, 16'h0400, 1'b0, 1'b0, 2, 5);
    directed(16'hC900, 16'hFFF6, 1'b0, 1'b0, 9, 5);

    // Reset while shifting: int_out holds 0xFFF6 beforehand.
    fp_in    = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(int_out == 16'h0 && !out_valid && !ovf && !unf, "midreset_outputs",
        {int_out, 13'd0, out_valid, ovf, unf}, 32'd0);
    chk(in_ready, "midreset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    directed(16'hC900, 16'hFFF6, 1'b0, 1'b0, 9, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 0) e = 5'($urandom_range(15, 29));
      else                           e = 5'($urandom_range(0, 31));
      conv({1'($urandom), e, 10'($urandom)}, int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fpa_fp16_to_int.md
# fpa_fp16_to_int

Multi-cycle converter that takes one 16-bit floating-point word from the adder's output encoding and returns a signed 16-bit integer. The input encoding is the one `FPSUM` uses: sign bit, 5-bit exponent with bias 15, and a 10-bit fraction with an implicit leading 1. This block sits on the read-out side of the floating-point adder datapath and converts adder results for integer consumers. It uses a valid/ready handshake on both sides and a bit-serial alignment shifter.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  Single clock; every register updates on its rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- fp_in  input  16  Operand: `[15]` sign, `[14:10]` exponent, `[9:0]` fraction.
- in_valid  input  1  `fp_in` is valid.
- in_ready  output  1  Converter can accept. It is 1 exactly when the FSM is in IDLE.
- int_out  output  16  Two's-complement result, registered.
- out_valid  output  1  `int_out`, `ovf` and `unf` are valid.
- out_ready  input  1  Consumer takes the result.
- ovf  output  1  Result saturated because the value is out of int16 range.
- unf  output  1  Nonzero input truncated to 0 because its magnitude is below 1.

## Operation
- The FSM has four states: IDLE, SHIFT, FIN, DONE.
- Reset (`rst_n` low, at any time including mid-conversion):
  - State goes to IDLE.
  - `int_out`, `out_valid`, `ovf` and `unf` go to 0, and the shift counter goes to 0.
  - `in_ready` is 1 in IDLE, so it reads 1 once reset is applied.
- Acceptance: on a rising edge with state IDLE and `in_valid` = 1, the operand is decoded into sign S, exponent E and fraction M, then classified. First match wins:
  1. E = 0 (zero encoding; the fraction is ignored): result 0x0000, no flags, go to DONE.
  2. E = 31: saturate to 0x7FFF if S = 0, or 0x8000 if S = 1. Set `ovf` = 1 and go to DONE.
  3. E = 30, S = 1 and M = 0: result 0x8000, no flags, go to DONE.
  4. E = 30, any other combination: saturate as in rule 2, set `ovf` = 1, go to DONE.
  5. 1 ≤ E ≤ 14: result 0x0000, set `unf` = 1, go to DONE.
  6. 15 ≤ E ≤ 29: load `mag` = {5'b0, 1'b1, M} (16 bits) and `cnt` = |E − 25|. Record the direction: left if E > 25, right otherwise. Go to SHIFT.
- SHIFT:
  - If `cnt` = 0, go to FIN.
  - Otherwise shift `mag` one bit per cycle in the recorded direction, zero-filling, and decrement `cnt`.
  - Right shifts truncate toward zero.
  - The maximum is 10 right shifts (E = 15) or 4 left shifts (E = 29).
- FIN: `int_out` = S ? (~`mag` + 1) : `mag`. Flags are 0. Go to DONE.
  - The magnitude after shifting is at most 0x7FF0, so FIN never overflows.
- DONE:
  - `out_valid` = 1.
  - `int_out`, `ovf` and `unf` are held stable until a rising edge with `out_ready` = 1; that edge returns the FSM to IDLE.
  - `out_valid` deasserts on that same edge.
- Flags are written on every classification, so they never carry over from the previous result.
- While not in IDLE, `in_valid` and `fp_in` are ignored, and no operand is queued.

## Timing
- Latency counts rising edges from the accepting edge to the edge on which `out_valid` rises:
  - Classes 1–5: 1 edge.
  - Class 6: n + 2 edges, where n = |E − 25|. That is n shift edges, then the SHIFT→FIN edge, then the FIN→DONE edge.
- Throughput: at most one conversion in flight. The earliest next acceptance is the edge after the one that consumed the result, because `in_ready` rises on the consuming edge.
- `out_valid`, `int_out`, `ovf` and `unf` are registered outputs. `in_ready` is a decode of the state register.
- Holding `out_ready` = 1 permanently gives a result lifetime of exactly one cycle.

## Test plan
- 0x3C00 (1.0), `out_ready` = 1: `out_valid` rises 12 edges after acceptance; `int_out` = 0x0001, `ovf` = 0, `unf` = 0.
- 0xC900 (−10.0): latency 9; `int_out` = 0xFFF6. Then 0x77FF (32752): latency 6; `int_out` = 0x7FF0.
- Range edges, each with latency 1:
  - 0x7BFF → 0x7FFF with `ovf` = 1.
  - 0xFC00 → 0x8000 with `ovf` = 1.
  - 0xF800 → 0x8000 with `ovf` = 0.
- 0x3800 (0.5) → 0x0000 with `unf` = 1. Then 0x0000 and 0x03FF → 0x0000 with both flags 0.
- Backpressure:
  - Hold `out_ready` = 0 for 5 cycles after `out_valid` rises; the outputs must stay stable and `in_ready` must stay 0.
  - A different `fp_in` presented with `in_valid` = 1 during those cycles must be ignored.
  - Raising `out_ready` consumes the result, and `in_ready` = 1 on the next cycle.
- Reset mid-SHIFT:
  - Drive `rst_n` low 3 edges after accepting 0x3C00; all outputs go to 0 at once and the state goes to IDLE.
  - After releasing reset, 0xC900 converts cleanly to 0xFFF6.
